// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, mid-bit sampling from a baud
// divider, configurable data/parity/stop format and a valid/ack output register.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 data_ack,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
  localparam logic          ODD       = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_next;
  logic                 sync1, rx_s, rx_prev;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shift;
  logic                 perr, ferr, stop_idx;
  logic                 half_tick, full_tick, fall, stop_last, done;

  assign half_tick = (cnt == HALF_LAST);
  assign full_tick = (cnt == FULL_LAST);
  assign fall      = ~rx_s & rx_prev;
  assign stop_last = (STOP_BITS == 1) || stop_idx;
  assign busy      = (state != IDLE);

  // Synchroniser and edge-detect history idle high so reset never looks like a start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= rx;
      rx_s    <= sync1;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    done       = 1'b0;
    case (state)
      IDLE:   if (fall) state_next = START;
      START:  if (half_tick) state_next = rx_s ? IDLE : DATA;
      DATA:   if (full_tick && idx == IDX_LAST)
                state_next = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY: if (full_tick) state_next = STOP;
      STOP:   if (full_tick && stop_last) begin
                done       = 1'b1;
                state_next = IDLE;
              end
      default: state_next = IDLE;
    endcase
  end

  // Counter restarts at the half-bit point so every later sample lands mid-bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      idx      <= '0;
      shift    <= '0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
      stop_idx <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt      <= '0;
          idx      <= '0;
          perr     <= 1'b0;
          ferr     <= 1'b0;
          stop_idx <= 1'b0;
        end
        START:   cnt <= half_tick ? '0 : cnt + 1'b1;
        default: cnt <= full_tick ? '0 : cnt + 1'b1;
      endcase
      if (full_tick) begin
        case (state)
          DATA: begin
            shift <= {rx_s, shift[DATA_BITS-1:1]};
            idx   <= idx + 1'b1;
          end
          PARITY: perr <= ((^shift) ^ rx_s) != ODD;
          STOP: begin
            ferr     <= ferr | ~rx_s;
            stop_idx <= stop_idx + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // A completion always wins over an ack on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (done) begin
      data       <= shift;
      parity_err <= (PARITY_EN != 0) ? perr : 1'b0;
      frame_err  <= ferr | ~rx_s;
      valid      <= 1'b1;
      overrun    <= valid & ~data_ack;
    end else if (valid && data_ack) begin
      valid   <= 1'b0;
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three instances (8N1, 8E1, 9N2) at 16 clocks per bit,
// checked against expectations derived from the line-level frame contents.
module tb_uart_rx_param;

  localparam int C = 16;

  logic       clk, reset;
  logic       rx_a, rx_p, rx_w, ack_a, ack_p, ack_w;
  logic [7:0] data_a, data_p;
  logic [8:0] data_w;
  logic       valid_a, perr_a, ferr_a, ovr_a, busy_a;
  logic       valid_p, perr_p, ferr_p, ovr_p, busy_p;
  logic       valid_w, perr_w, ferr_w, ovr_w, busy_w;

  int         n_tests, n_fail;
  longint     fall_t [3];
  longint     rise_t [3];
  logic [2:0] vq;

  uart_rx_param #(.CLKS_PER_BIT(C)) dut_a (
    .clk(clk), .reset(reset), .rx(rx_a), .data_ack(ack_a), .data(data_a),
    .valid(valid_a), .parity_err(perr_a), .frame_err(ferr_a), .overrun(ovr_a), .busy(busy_a));

  uart_rx_param #(.CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .clk(clk), .reset(reset), .rx(rx_p), .data_ack(ack_p), .data(data_p),
    .valid(valid_p), .parity_err(perr_p), .frame_err(ferr_p), .overrun(ovr_p), .busy(busy_p));

  uart_rx_param #(.CLKS_PER_BIT(C), .DATA_BITS(9), .STOP_BITS(2)) dut_w (
    .clk(clk), .reset(reset), .rx(rx_w), .data_ack(ack_w), .data(data_w),
    .valid(valid_w), .parity_err(perr_w), .frame_err(ferr_w), .overrun(ovr_w), .busy(busy_w));

  always #5 clk = ~clk;

  // Record the negedge at which each valid first rises, for latency checks.
  always @(negedge clk) begin
    vq <= {valid_w, valid_p, valid_a};
    if (valid_a && !vq[0]) rise_t[0] <= $time;
    if (valid_w && !vq[2]) rise_t[2] <= $time;
  end

  function automatic logic [8:0] get_data(input int sel);
    case (sel)
      0:       return {1'b0, data_a};
      1:       return {1'b0, data_p};
      default: return data_w;
    endcase
  endfunction

  // {valid, parity_err, frame_err, overrun, busy}
  function automatic logic [4:0] get_flags(input int sel);
    case (sel)
      0:       return {valid_a, perr_a, ferr_a, ovr_a, busy_a};
      1:       return {valid_p, perr_p, ferr_p, ovr_p, busy_p};
      default: return {valid_w, perr_w, ferr_w, ovr_w, busy_w};
    endcase
  endfunction

  task automatic set_rx(input int sel, input logic v);
    case (sel)
      0:       rx_a = v;
      1:       rx_p = v;
      default: rx_w = v;
    endcase
  endtask

  task automatic set_ack(input int sel, input logic v);
    case (sel)
      0:       ack_a = v;
      1:       ack_p = v;
      default: ack_w = v;
    endcase
  endtask

  task automatic hold_bit(input int sel, input logic v);
    set_rx(sel, v);
    repeat (C) @(posedge clk);
    #1;
  endtask

  // One idle-high cycle, then start, data LSB first, optional parity, stop bits.
  task automatic send_frame(input int sel, input logic [8:0] d, input int nbits,
                            input bit pen, input bit pbit, input int nstop, input bit szero);
    set_rx(sel, 1'b1);
    @(posedge clk);
    #1;
    fall_t[sel] = $time;
    hold_bit(sel, 1'b0);
    for (int i = 0; i < nbits; i++) hold_bit(sel, d[i]);
    if (pen) hold_bit(sel, pbit);
    for (int i = 0; i < nstop; i++) hold_bit(sel, !szero);
  endtask

  task automatic pulse_ack(input int sel);
    set_ack(sel, 1'b1);
    @(posedge clk);
    #1;
    set_ack(sel, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      n_tests++;
      if ({get_data(s), get_flags(s)} !== 14'h0) begin
        n_fail++;
        $display("[TB] FAIL reset_state inst%0d: got %h required 0", s, {get_data(s), get_flags(s)});
      end
    end
  endtask

  task automatic test_basic;
    int lat;
    send_frame(0, 9'h0A5, 8, 0, 0, 1, 0);
    @(negedge clk);
    n_tests++;
    if (get_data(0) !== 9'h0A5) begin
      n_fail++; $display("[TB] FAIL basic_data: got %h required a5", get_data(0));
    end
    n_tests++;
    if (get_flags(0) !== 5'b10000) begin
      n_fail++; $display("[TB] FAIL basic_flags: got %b required 10000", get_flags(0));
    end
    lat = int'((rise_t[0] - fall_t[0] - 4) / 10);
    n_tests++;
    if (lat < 2 + C/2 + C*9 - 1 || lat > 2 + C/2 + C*9 + 1) begin
      n_fail++; $display("[TB] FAIL basic_latency: got %0d cycles required %0d +-1", lat, 2 + C/2 + C*9);
    end
    pulse_ack(0);
    n_tests++;
    if (get_flags(0) !== 5'b00000) begin
      n_fail++; $display("[TB] FAIL basic_ack_clear: got %b required 00000", get_flags(0));
    end
  endtask

  task automatic test_glitch;
    @(posedge clk);
    #1;
    rx_a = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx_a = 1'b1;
    @(negedge clk);
    n_tests++;
    if (get_flags(0) !== 5'b00001) begin
      n_fail++; $display("[TB] FAIL glitch_busy: got %b required 00001", get_flags(0));
    end
    repeat (20) @(negedge clk);
    n_tests++;
    if (get_flags(0) !== 5'b00000) begin
      n_fail++; $display("[TB] FAIL glitch_idle: got %b required 00000", get_flags(0));
    end
    n_tests++;
    if (get_data(0) !== 9'h0A5) begin
      n_fail++; $display("[TB] FAIL glitch_data_held: got %h required a5", get_data(0));
    end
  endtask

  task automatic test_parity;
    for (int k = 0; k < 2; k++) begin
      logic pbit, exp_perr;
      pbit     = (k == 0);
      exp_perr = ((^8'h07) ^ pbit) != 1'b0;
      send_frame(1, 9'h007, 8, 1, pbit, 1, 0);
      @(negedge clk);
      n_tests++;
      if (get_data(1) !== 9'h007) begin
        n_fail++; $display("[TB] FAIL parity_data pbit=%0b: got %h required 07", pbit, get_data(1));
      end
      n_tests++;
      if (get_flags(1) !== {1'b1, exp_perr, 3'b000}) begin
        n_fail++; $display("[TB] FAIL parity_flags pbit=%0b: got %b required %b", pbit, get_flags(1), {1'b1, exp_perr, 3'b000});
      end
      pulse_ack(1);
    end
  endtask

  task automatic test_break;
    logic [8:0] d;
    int bad;
    d = {1'b0, 8'($urandom)};
    send_frame(0, d, 8, 0, 0, 1, 1);
    @(negedge clk);
    n_tests++;
    if (get_data(0) !== d || get_flags(0) !== 5'b10100) begin
      n_fail++; $display("[TB] FAIL break_word: got %h/%b required %h/10100", get_data(0), get_flags(0), d);
    end
    pulse_ack(0);
    bad = 0;
    repeat (40 * C) begin
      @(negedge clk);
      if (valid_a || busy_a) bad++;
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++; $display("[TB] FAIL break_no_retrigger: got %0d active cycles required 0", bad);
    end
    rx_a = 1'b1;
    repeat (2 * C) @(posedge clk);
    #1;
    send_frame(0, 9'h03C, 8, 0, 0, 1, 0);
    @(negedge clk);
    n_tests++;
    if (get_data(0) !== 9'h03C || get_flags(0) !== 5'b10000) begin
      n_fail++; $display("[TB] FAIL break_recover: got %h/%b required 3c/10000", get_data(0), get_flags(0));
    end
    pulse_ack(0);
  endtask

  task automatic test_back_to_back;
    send_frame(0, 9'h011, 8, 0, 0, 1, 0);
    send_frame(0, 9'h022, 8, 0, 0, 1, 0);
    @(negedge clk);
    n_tests++;
    if (get_data(0) !== 9'h022 || get_flags(0) !== 5'b10010) begin
      n_fail++; $display("[TB] FAIL overrun_set: got %h/%b required 22/10010", get_data(0), get_flags(0));
    end
    pulse_ack(0);
    n_tests++;
    if (get_flags(0) !== 5'b00000) begin
      n_fail++; $display("[TB] FAIL overrun_ack_clear: got %b required 00000", get_flags(0));
    end
    send_frame(0, 9'h011, 8, 0, 0, 1, 0);
    fork
      send_frame(0, 9'h022, 8, 0, 0, 1, 0);
      begin
        repeat (2 + C/2 + C*9) @(posedge clk);
        #1;
        ack_a = 1'b1;
        @(posedge clk);
        #1;
        ack_a = 1'b0;
      end
    join
    @(negedge clk);
    n_tests++;
    if (get_data(0) !== 9'h022 || get_flags(0) !== 5'b10000) begin
      n_fail++; $display("[TB] FAIL ack_on_completion: got %h/%b required 22/10000", get_data(0), get_flags(0));
    end
    pulse_ack(0);
  endtask

  task automatic test_random;
    for (int k = 0; k < 8; k++) begin
      logic [7:0] d;
      logic       pbit, szero, exp_perr;
      d        = 8'($urandom);
      pbit     = (^d) ^ 1'($urandom_range(0, 1));
      szero    = ($urandom_range(0, 3) == 0);
      exp_perr = ((^d) ^ pbit) != 1'b0;
      send_frame(1, {1'b0, d}, 8, 1, pbit, 1, szero);
      @(negedge clk);
      n_tests++;
      if (get_data(1) !== {1'b0, d} || get_flags(1) !== {1'b1, exp_perr, szero, 2'b00}) begin
        n_fail++;
        $display("[TB] FAIL random_frame%0d: got %h/%b required %h/%b", k, get_data(1), get_flags(1), d, {1'b1, exp_perr, szero, 2'b00});
      end
      pulse_ack(1);
      n_tests++;
      if (valid_p !== 1'b0) begin
        n_fail++; $display("[TB] FAIL random_ack%0d: valid got %b required 0", k, valid_p);
      end
    end
  endtask

  task automatic test_wide_reset;
    int lat;
    logic [8:0] d2;
    send_frame(2, 9'h1FF, 9, 0, 0, 2, 0);
    @(negedge clk);
    n_tests++;
    if (get_data(2) !== 9'h1FF || get_flags(2) !== 5'b10000) begin
      n_fail++; $display("[TB] FAIL wide_word: got %h/%b required 1ff/10000", get_data(2), get_flags(2));
    end
    lat = int'((rise_t[2] - fall_t[2] - 4) / 10);
    n_tests++;
    if (lat < 2 + C/2 + C*11 - 1 || lat > 2 + C/2 + C*11 + 1) begin
      n_fail++; $display("[TB] FAIL wide_latency: got %0d cycles required %0d +-1", lat, 2 + C/2 + C*11);
    end
    // Bits 4..8 and the stops are high, so the rest of the frame after reset has no falling edge.
    d2 = 9'h1F0 | 9'($urandom_range(0, 15));
    fork
      send_frame(2, d2, 9, 0, 0, 2, 0);
      begin
        repeat (C*5 + 9) @(posedge clk);
        #1;
        n_tests++;
        if (busy_w !== 1'b1) begin
          n_fail++; $display("[TB] FAIL wide_busy_mid_frame: got %b required 1", busy_w);
        end
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({get_data(2), get_flags(2)} !== 14'h0) begin
          n_fail++; $display("[TB] FAIL wide_reset_outputs: got %h required 0", {get_data(2), get_flags(2)});
        end
      end
    join
    repeat (3 * C) @(negedge clk);
    n_tests++;
    if ({get_data(2), get_flags(2)} !== 14'h0) begin
      n_fail++; $display("[TB] FAIL wide_no_valid_after_reset: got %h required 0", {get_data(2), get_flags(2)});
    end
  endtask

  initial begin
    clk = 1'b0;
    reset = 1'b0;
    rx_a = 1'b1; rx_p = 1'b1; rx_w = 1'b1;
    ack_a = 1'b0; ack_p = 1'b0; ack_w = 1'b0;
    n_tests = 0;
    n_fail = 0;
    test_reset;
    test_basic;
    test_glitch;
    test_parity;
    test_break;
    test_back_to_back;
    test_random;
    test_wide_reset;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
